variable_node_update: RTL and testbench
=======================================

Name: variable_node_update

Overview:
- Variable-node processor of the min-sum LDPC decoder. It is the counterpart of the check node on the same per-edge value/enable handshake.
- It holds one channel LLR and accumulates the LLR plus all incoming check messages.
- It returns extrinsic messages (total minus own edge) to each connected check node and produces a registered hard-decision bit each iteration.

Parameters:
weight, 3, number of check nodes connected to this variable node
length, 15, two's-complement message width (LLR and edge messages)
acc_extra, 3, accumulator guard bits; must satisfy weight+1 <= 2**acc_extra

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
channel_value_input  input  length  channel LLR, two's complement
channel_load  input  1  latch channel_value_input, start a new codeword
check_value_input  input  weight*length  check messages; edge k at [length*(k+1)-1 : length*k]
check_enable_input  input  weight  per-edge check message valid
decision_down  input  1  global parity decision finished
decision_success  input  1  global parity decision passed (valid with decision_down)
variable_value_output  output  weight*length  extrinsic message per edge, same packing
variable_enable_output  output  weight  per-edge extrinsic valid
hard_decision  output  1  sign of latest total (1 = negative)
hard_valid  output  1  one-cycle pulse when hard_decision updated
iter_count  output  8  completed update rounds since channel_load, saturates at 255

Behaviour:
- Reset (async, rst=0): state=IDLE; all variable_value_output=0; variable_enable_output=0; hard_decision=0; hard_valid=0; iter_count=0; channel register=0; accumulator=0; j=0.
- Arithmetic:
  - Accumulator is length+acc_extra bits, sign-extended inputs, no internal overflow.
  - Extrinsic out = total − check[j], saturated to [−(2^(length−1)−1), +(2^(length−1)−1)]. The most-negative code is never emitted.
- Ack rule, any state except DONE: variable_enable_output[k] clears to 0 the cycle after check_enable_input[k]=0 is sampled.
- hard_valid defaults to 0 every cycle unless set below.

State machine:
- IDLE:
  - channel_load=1 → latch channel_value_input, iter_count<=0, go WAIT_CHECK.
- WAIT_CHECK:
  - When all check_enable_input=1 AND all variable_enable_output=0: total<=sext(channel), j<=0, go SUM.
- SUM:
  - j<weight: total<=total+sext(check[j]), j<=j+1.
  - j==weight: j<=0, go UPDATE.
  - Check inputs are sampled during SUM only and must stay stable through UPDATE (the check node guarantees this while its enables are high).
- UPDATE:
  - j<weight: variable_value_output[j]<=sat(total−check[j]), variable_enable_output[j]<=1, j<=j+1.
  - j==weight: hard_decision<=total MSB, hard_valid<=1, iter_count<=sat+1, j<=0, go WAIT_CHECK.
- DONE:
  - All variable_enable_output held 0; values and hard_decision frozen.
  - channel_load → same action as in IDLE.

Timing:
- Round = 1 (WAIT_CHECK exit) + weight+1 (SUM) + weight+1 (UPDATE) cycles.
- variable_enable_output[k] rises at the UPDATE cycle with j=k.

Boundaries:
- decision_down=1 && decision_success=1 in WAIT_CHECK/SUM/UPDATE → go DONE next cycle; variable_enable_output cleared, round aborted, no hard_valid.
- decision_down with decision_success=0 → ignored; iteration continues.
- channel_load outside IDLE/DONE is ignored.
- total==0 → hard_decision=0.
- First round after load: check node comes out of reset with enables=1 and values=0, so outputs equal the channel LLR.
- Reset mid-round → immediate return to reset values; no partial outputs persist.

Test Plan:
- Reset, load 5, check node enables=1 with values 0 → outputs 5,5,5; enables rise on consecutive cycles; hard_decision=0; hard_valid pulse; iter_count=1.
- Ack: drop check_enable to 0 → variable_enable clears next cycle. Then give checks 3, −7, 2 with enables=1 → outputs 0, 10, 1; hard_decision=0; iter_count=2.
- Saturation: load 16000, checks 16000, 16000, 0 → all outputs 16383. Load −16000, checks −16000, −16000, 0 → all outputs −16383; hard_decision=1.
- decision_down=1 with success=1 during SUM → DONE: enables 0, no hard_valid. channel_load 7 then restarts and iter_count resets.
- decision_down=1 with success=0 → no effect; round completes normally.
- Assert rst during UPDATE after edge 0 is emitted → all outputs 0, state IDLE; a subsequent load runs a clean round.

Source files
------------

// File: rtl/variable_node_update.sv
// Min-sum LDPC variable node: accumulates the channel LLR with all check messages,
// returns saturated extrinsic messages per edge and a registered hard decision.
module variable_node_update #(
    parameter int weight    = 3,
    parameter int length    = 15,
    parameter int acc_extra = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [length-1:0]        channel_value_input,
    input  logic                     channel_load,
    input  logic [weight*length-1:0] check_value_input,
    input  logic [weight-1:0]        check_enable_input,
    input  logic                     decision_down,
    input  logic                     decision_success,
    output logic [weight*length-1:0] variable_value_output,
    output logic [weight-1:0]        variable_enable_output,
    output logic                     hard_decision,
    output logic                     hard_valid,
    output logic [7:0]               iter_count,
    output logic [2:0]               state_dbg
);
    // Handshake: per edge k, variable_enable_output[k] rises when a new extrinsic value
    // is presented and stays high until check_enable_input[k] is seen low (ack), after
    // which it drops the following cycle.

    localparam int AW = length + acc_extra;
    localparam int JW = $clog2(weight + 1);

    localparam logic [length-1:0]        MAX_OUT = {1'b0, {(length-1){1'b1}}};
    localparam logic [length-1:0]        MIN_OUT = ~MAX_OUT + 1'b1;
    localparam logic signed [AW-1:0]     SAT_POS = {{acc_extra{1'b0}}, MAX_OUT};
    localparam logic signed [AW-1:0]     SAT_NEG = {{acc_extra{1'b1}}, MIN_OUT};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_CHECK = 3'd1,
        S_SUM        = 3'd2,
        S_UPDATE     = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                 state_q;
    logic [length-1:0]      channel_q;
    logic signed [AW-1:0]   total_q;
    logic [JW-1:0]          j_q;

    logic [length-1:0]      cur_check;
    logic signed [AW-1:0]   check_ext;
    logic signed [AW-1:0]   diff_ext;
    logic [length-1:0]      sat_val;
    logic                   abort;

    assign state_dbg = state_q;
    assign abort = decision_down && decision_success &&
                   (state_q == S_WAIT_CHECK || state_q == S_SUM || state_q == S_UPDATE);

    always_comb begin
        cur_check = '0;
        for (int k = 0; k < weight; k++) begin
            if (j_q == JW'(k)) cur_check = check_value_input[k*length +: length];
        end
        check_ext = {{acc_extra{cur_check[length-1]}}, cur_check};
        diff_ext  = total_q - check_ext;
        // Symmetric saturation: the most-negative code is never emitted.
        if (diff_ext > SAT_POS)      sat_val = MAX_OUT;
        else if (diff_ext < SAT_NEG) sat_val = MIN_OUT;
        else                         sat_val = diff_ext[length-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                <= S_IDLE;
            channel_q              <= '0;
            total_q                <= '0;
            j_q                    <= '0;
            variable_value_output  <= '0;
            variable_enable_output <= '0;
            hard_decision          <= 1'b0;
            hard_valid             <= 1'b0;
            iter_count             <= '0;
        end else begin
            hard_valid <= 1'b0;
            if (state_q != S_DONE) begin
                for (int k = 0; k < weight; k++) begin
                    if (!check_enable_input[k]) variable_enable_output[k] <= 1'b0;
                end
            end
            if (abort) begin
                state_q                <= S_DONE;
                variable_enable_output <= '0;
                j_q                    <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (channel_load) begin
                            channel_q  <= channel_value_input;
                            iter_count <= '0;
                            state_q    <= S_WAIT_CHECK;
                        end
                    end
                    S_WAIT_CHECK: begin
                        if (&check_enable_input && variable_enable_output == '0) begin
                            total_q <= {{acc_extra{channel_q[length-1]}}, channel_q};
                            j_q     <= '0;
                            state_q <= S_SUM;
                        end
                    end
                    S_SUM: begin
                        if (j_q < JW'(weight)) begin
                            total_q <= total_q + check_ext;
                            j_q     <= j_q + 1'b1;
                        end else begin
                            j_q     <= '0;
                            state_q <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        if (j_q < JW'(weight)) begin
                            for (int k = 0; k < weight; k++) begin
                                if (j_q == JW'(k)) begin
                                    variable_value_output[k*length +: length] <= sat_val;
                                    variable_enable_output[k]                 <= 1'b1;
                                end
                            end
                            j_q <= j_q + 1'b1;
                        end else begin
                            hard_decision <= total_q[AW-1];
                            hard_valid    <= 1'b1;
                            if (iter_count != 8'hFF) iter_count <= iter_count + 8'd1;
                            j_q     <= '0;
                            state_q <= S_WAIT_CHECK;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_variable_node_update.sv
// Bench for variable_node_update: scenario tasks plus a scoreboard monitor that pops
// expected extrinsic values as each edge enable rises.
module tb_variable_node_update;
    localparam int W = 3;
    localparam int L = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [L-1:0]   channel_value_input = '0;
    logic           channel_load = 1'b0;
    logic [W*L-1:0] check_value_input = '0;
    logic [W-1:0]   check_enable_input = '0;
    logic           decision_down = 1'b0;
    logic           decision_success = 1'b0;
    logic [W*L-1:0] variable_value_output;
    logic [W-1:0]   variable_enable_output;
    logic           hard_decision;
    logic           hard_valid;
    logic [7:0]     iter_count;
    logic [2:0]     state_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc[W];
    logic [W-1:0] prev_en = '0;
    logic [L-1:0] exp_q[$];
    logic         exp_hard;

    variable_node_update #(.weight(W), .length(L), .acc_extra(3)) dut (
        .clk(clk), .rst(rst),
        .channel_value_input(channel_value_input), .channel_load(channel_load),
        .check_value_input(check_value_input), .check_enable_input(check_enable_input),
        .decision_down(decision_down), .decision_success(decision_success),
        .variable_value_output(variable_value_output),
        .variable_enable_output(variable_enable_output),
        .hard_decision(hard_decision), .hard_valid(hard_valid),
        .iter_count(iter_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: one expected value per rising edge enable, in edge order.
    always @(negedge clk) begin
        for (int k = 0; k < W; k++) begin
            if (variable_enable_output[k] && !prev_en[k]) begin
                logic [L-1:0] e;
                rise_cyc[k] = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_edge%0d got=%0d exp=none", k,
                             $signed(variable_value_output[k*L +: L]));
                end else begin
                    e = exp_q.pop_front();
                    if (variable_value_output[k*L +: L] !== e) begin
                        failures++;
                        $display("FAIL edge%0d_value got=%0d exp=%0d", k,
                                 $signed(variable_value_output[k*L +: L]), $signed(e));
                    end
                end
            end
        end
        prev_en = variable_enable_output;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [L-1:0] sat15(int v);
        if (v > 16383) v = 16383;
        if (v < -16383) v = -16383;
        return L'(v);
    endfunction

    task automatic drive_checks(input int a, input int b, input int c, input logic [W-1:0] en);
        check_value_input  = {L'(c), L'(b), L'(a)};
        check_enable_input = en;
    endtask

    task automatic push_round(input int ch, input int a, input int b, input int c);
        int t;
        t = ch + a + b + c;
        exp_q.push_back(sat15(t - a));
        exp_q.push_back(sat15(t - b));
        exp_q.push_back(sat15(t - c));
        exp_hard = (t < 0);
    endtask

    task automatic load(input int v);
        tick();
        channel_value_input = L'(v);
        channel_load = 1'b1;
        tick();
        channel_load = 1'b0;
    endtask

    task automatic wait_hard_valid(output bit seen, output int at);
        seen = 0;
        at = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hard_valid) begin
                seen = 1;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic abort_now();
        tick();
        decision_down = 1'b1;
        decision_success = 1'b1;
        tick();
        decision_down = 1'b0;
        decision_success = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (variable_value_output !== '0 || variable_enable_output !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b exp=0/0", variable_value_output, variable_enable_output);
        end
        checks++;
        if (hard_decision !== 1'b0 || hard_valid !== 1'b0 || iter_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_hard got=%b/%b/%0d exp=0/0/0", hard_decision, hard_valid, iter_count);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", state_dbg);
        end
        rst = 1'b1;
    endtask

    task automatic test_first_round();
        bit seen;
        int at;
        drive_checks(0, 0, 0, 3'b111);
        push_round(5, 0, 0, 0);
        load(5);
        wait_hard_valid(seen, at);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL first_hard_valid got=timeout exp=pulse");
        end
        checks++;
        if (rise_cyc[1] != rise_cyc[0] + 1 || rise_cyc[2] != rise_cyc[1] + 1 || at != rise_cyc[2] + 1) begin
            failures++;
            $display("FAIL first_timing got=%0d,%0d,%0d,%0d exp=consecutive", rise_cyc[0], rise_cyc[1], rise_cyc[2], at);
        end
        checks++;
        if (hard_decision !== exp_hard || iter_count !== 8'd1) begin
            failures++;
            $display("FAIL first_hard_iter got=%b/%0d exp=%b/1", hard_decision, iter_count, exp_hard);
        end
        tick();
        checks++;
        if (hard_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_pulse_width got=%b exp=0", hard_valid);
        end
    endtask

    task automatic test_ack_and_mixed();
        bit seen;
        int at;
        tick();
        check_enable_input = 3'b000;
        checks++;
        if (variable_enable_output !== 3'b111) begin
            failures++;
            $display("FAIL ack_hold got=%b exp=111", variable_enable_output);
        end
        tick();
        checks++;
        if (variable_enable_output !== 3'b000) begin
            failures++;
            $display("FAIL ack_clear got=%b exp=000", variable_enable_output);
        end
        push_round(5, 3, -7, 2);
        drive_checks(3, -7, 2, 3'b111);
        wait_hard_valid(seen, at);
        checks++;
        if (!seen || hard_decision !== exp_hard || iter_count !== 8'd2) begin
            failures++;
            $display("FAIL mixed_round got=%b/%b/%0d exp=1/%b/2", seen, hard_decision, iter_count, exp_hard);
        end
    endtask

    task automatic test_saturation();
        bit seen;
        int at;
        abort_now();
        checks++;
        if (state_dbg !== 3'd4 || variable_enable_output !== 3'b000) begin
            failures++;
            $display("FAIL wait_abort got=%0d/%b exp=4/000", state_dbg, variable_enable_output);
        end
        drive_checks(16000, 16000, 0, 3'b111);
        push_round(16000, 16000, 16000, 0);
        load(16000);
        wait_hard_valid(seen, at);
        checks++;
        if (!seen || hard_decision !== 1'b0 || iter_count !== 8'd1) begin
            failures++;
            $display("FAIL sat_pos_round got=%b/%b/%0d exp=1/0/1", seen, hard_decision, iter_count);
        end
        abort_now();
        drive_checks(-16000, -16000, 0, 3'b111);
        push_round(-16000, -16000, -16000, 0);
        load(-16000);
        wait_hard_valid(seen, at);
        checks++;
        if (!seen || hard_decision !== 1'b1 || iter_count !== 8'd1) begin
            failures++;
            $display("FAIL sat_neg_round got=%b/%b/%0d exp=1/1/1", seen, hard_decision, iter_count);
        end
    endtask

    task automatic test_abort_in_sum();
        bit seen;
        bit in_sum;
        int at;
        int pulses;
        tick();
        check_enable_input = 3'b000;
        tick();
        drive_checks(1, 1, 1, 3'b111);
        in_sum = 0;
        for (int i = 0; i < 20 && !in_sum; i++) begin
            tick();
            if (state_dbg == 3'd2) in_sum = 1;
        end
        checks++;
        if (!in_sum) begin
            failures++;
            $display("FAIL reach_sum got=%0d exp=2", state_dbg);
        end
        decision_down = 1'b1;
        decision_success = 1'b1;
        tick();
        decision_down = 1'b0;
        decision_success = 1'b0;
        checks++;
        if (state_dbg !== 3'd4 || variable_enable_output !== 3'b000) begin
            failures++;
            $display("FAIL sum_abort got=%0d/%b exp=4/000", state_dbg, variable_enable_output);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (hard_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || variable_enable_output !== 3'b000) begin
            failures++;
            $display("FAIL done_quiet got=%0d/%b exp=0/000", pulses, variable_enable_output);
        end
        drive_checks(0, 0, 0, 3'b111);
        push_round(7, 0, 0, 0);
        load(7);
        wait_hard_valid(seen, at);
        checks++;
        if (!seen || hard_decision !== 1'b0 || iter_count !== 8'd1) begin
            failures++;
            $display("FAIL restart_round got=%b/%b/%0d exp=1/0/1", seen, hard_decision, iter_count);
        end
    endtask

    task automatic test_decision_fail();
        bit seen;
        int at;
        tick();
        check_enable_input = 3'b000;
        channel_load = 1'b1;
        channel_value_input = L'(100);
        tick();
        channel_load = 1'b0;
        decision_down = 1'b1;
        decision_success = 1'b0;
        push_round(7, 4, -2, 1);
        drive_checks(4, -2, 1, 3'b111);
        wait_hard_valid(seen, at);
        decision_down = 1'b0;
        checks++;
        if (!seen || hard_decision !== exp_hard || iter_count !== 8'd2) begin
            failures++;
            $display("FAIL fail_decision_round got=%b/%b/%0d exp=1/%b/2", seen, hard_decision, iter_count, exp_hard);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit got0;
        int at;
        tick();
        check_enable_input = 3'b000;
        tick();
        exp_q.push_back(sat15(7 + 1 + 1 + 1 - 1));
        drive_checks(1, 1, 1, 3'b111);
        got0 = 0;
        for (int i = 0; i < 30 && !got0; i++) begin
            tick();
            if (variable_enable_output[0]) got0 = 1;
        end
        checks++;
        if (!got0 || variable_enable_output[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_edge0 got=%b exp=001", variable_enable_output);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (variable_value_output !== '0 || variable_enable_output !== '0 || state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h/%b/%0d exp=0/000/0", variable_value_output, variable_enable_output, state_dbg);
        end
        checks++;
        if (iter_count !== 8'd0 || hard_decision !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_hard got=%0d/%b exp=0/0", iter_count, hard_decision);
        end
        tick();
        rst = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_queue got=%0d exp=0", exp_q.size());
        end
        drive_checks(0, 0, 0, 3'b111);
        push_round(-9, 0, 0, 0);
        load(-9);
        wait_hard_valid(seen, at);
        checks++;
        if (!seen || hard_decision !== 1'b1 || iter_count !== 8'd1) begin
            failures++;
            $display("FAIL post_reset_round got=%b/%b/%0d exp=1/1/1", seen, hard_decision, iter_count);
        end
        // Zero total must give a positive hard decision.
        tick();
        check_enable_input = 3'b000;
        tick();
        push_round(-9, 9, 0, 0);
        drive_checks(9, 0, 0, 3'b111);
        wait_hard_valid(seen, at);
        checks++;
        if (!seen || hard_decision !== 1'b0 || iter_count !== 8'd2) begin
            failures++;
            $display("FAIL zero_total got=%b/%b/%0d exp=1/0/2", seen, hard_decision, iter_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_ack_and_mixed();
        test_saturation();
        test_abort_in_sum();
        test_decision_fail();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
